// File: rtl/sim_mem_responder.sv
// sim_mem_responder
//   Multi-lane memory responder for simulation environments. Each lane
//   accepts load/store requests into a private response FIFO. Every entry
//   becomes visible on the D channel LATENCY edges after it was accepted.
//   All lanes share one word-addressed backing store. Stores are committed
//   at the accept edge. Loads capture their data at the accept edge from
//   the memory contents as they were before that edge.
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous, active-low reset
//   a_valid     per-lane request valid
//   a_ready     per-lane request ready (lane FIFO not full)
//   a_address   per-lane byte address, lane g at [DATA_WIDTH*g +: DATA_WIDTH]
//   a_is_store  per-lane request type (1 = store)
//   a_size      per-lane log2 access size
//   a_data      per-lane store data, LSB-aligned
//   d_valid     per-lane response valid
//   d_ready     per-lane response consumed
//   d_is_store  echo of request type
//   d_size      echo of request size (unclamped)
//   d_data      load data, zero-extended; 0 for stores
//   inflight    any lane FIFO non-empty
//   resp_count  running count of responses handed off (wraps)
//
// DEPTH must be a power of two >= 2 and MEM_WORDS a power of two.
// DATA_WIDTH must be >= 64.
module sim_mem_responder #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned LOGSIZE_WIDTH = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned MEM_WORDS     = 256
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LANES-1:0]               a_valid,
  output logic [NUM_LANES-1:0]               a_ready,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
  input  logic [NUM_LANES-1:0]               a_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
  output logic [NUM_LANES-1:0]               d_valid,
  input  logic [NUM_LANES-1:0]               d_ready,
  output logic [NUM_LANES-1:0]               d_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
  output logic [DATA_WIDTH*NUM_LANES-1:0]    d_data,
  output logic                               inflight,
  output logic [31:0]                        resp_count
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CDW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  // Backing store and per-lane FIFO storage
  logic [MEM_WORDS-1:0][DATA_WIDTH-1:0]               mem;
  logic [NUM_LANES-1:0][DEPTH-1:0][CDW-1:0]           q_cd;
  logic [NUM_LANES-1:0][DEPTH-1:0]                    q_store;
  logic [NUM_LANES-1:0][DEPTH-1:0][LOGSIZE_WIDTH-1:0] q_size;
  logic [NUM_LANES-1:0][DEPTH-1:0][DATA_WIDTH-1:0]    q_data;
  logic [NUM_LANES-1:0][PW-1:0]                       rd_ptr;
  logic [NUM_LANES-1:0][PW-1:0]                       wr_ptr;
  logic [NUM_LANES-1:0][CNTW-1:0]                     cnt;
  logic                                               ready_en;

  // Request decode
  logic [NUM_LANES-1:0][1:0]            eff_size;
  logic [NUM_LANES-1:0][2:0]            offs;
  logic [NUM_LANES-1:0][AW-1:0]         widx;
  logic [NUM_LANES-1:0][7:0]            bmask;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] st_shift;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] ld_data;
  logic [NUM_LANES-1:0]                 push;
  logic [NUM_LANES-1:0]                 pop;
  logic [NUM_LANES-1:0]                 nonempty;
  logic [31:0]                          pop_cnt;

  // Upper address bits wrap onto the backing store and are otherwise ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^a_address;

  always_comb begin
    logic [LOGSIZE_WIDTH-1:0] sz;
    logic [7:0]               low_mask;
    logic [DATA_WIDTH-1:0]    dmask;
    sz       = '0;
    low_mask = '0;
    dmask    = '0;
    for (int unsigned g = 0; g < NUM_LANES; g++) begin
      sz = a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH];
      eff_size[g] = (sz > LOGSIZE_WIDTH'(3)) ? 2'd3 : sz[1:0];
      // Clearing the low size bits forces natural alignment inside the word
      offs[g] = a_address[DATA_WIDTH*g +: 3] & ~((3'd1 << eff_size[g]) - 3'd1);
      widx[g] = a_address[DATA_WIDTH*g+3 +: AW];
      case (eff_size[g])
        2'd0:    low_mask = 8'h01;
        2'd1:    low_mask = 8'h03;
        2'd2:    low_mask = 8'h0F;
        default: low_mask = 8'hFF;
      endcase
      dmask = '0;
      for (int unsigned b = 0; b < 8; b++) begin
        dmask[8*b +: 8] = {8{low_mask[b]}};
      end
      bmask[g]    = low_mask << offs[g];
      st_shift[g] = a_data[DATA_WIDTH*g +: DATA_WIDTH] << {offs[g], 3'b000};
      ld_data[g]  = (mem[widx[g]] >> {offs[g], 3'b000}) & dmask;
    end
  end

  always_comb begin
    for (int unsigned g = 0; g < NUM_LANES; g++) begin
      nonempty[g]   = (cnt[g] != '0);
      a_ready[g]    = ready_en && (cnt[g] < CNTW'(DEPTH));
      d_valid[g]    = nonempty[g] && (q_cd[g][rd_ptr[g]] == '0);
      d_is_store[g] = d_valid[g] & q_store[g][rd_ptr[g]];
      d_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH] = d_valid[g] ? q_size[g][rd_ptr[g]] : '0;
      d_data[DATA_WIDTH*g +: DATA_WIDTH]       = d_valid[g] ? q_data[g][rd_ptr[g]] : '0;
    end
    inflight = |nonempty;
  end

  always_comb begin
    pop_cnt = '0;
    for (int unsigned g = 0; g < NUM_LANES; g++) begin
      push[g] = a_valid[g] & a_ready[g];
      pop[g]  = d_valid[g] & d_ready[g];
      pop_cnt = pop_cnt + 32'(pop[g]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en   <= 1'b0;
      resp_count <= '0;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      q_cd       <= '0;
      q_store    <= '0;
      q_size     <= '0;
      q_data     <= '0;
      mem        <= '0;
    end else begin
      ready_en   <= 1'b1;
      resp_count <= resp_count + pop_cnt;
      for (int unsigned g = 0; g < NUM_LANES; g++) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (q_cd[g][e] != '0) q_cd[g][e] <= q_cd[g][e] - CDW'(1);
        end
        if (push[g]) begin
          // Later assignment overrides the decrement above for the new slot
          q_cd[g][wr_ptr[g]]    <= CDW'(LATENCY);
          q_store[g][wr_ptr[g]] <= a_is_store[g];
          q_size[g][wr_ptr[g]]  <= a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH];
          q_data[g][wr_ptr[g]]  <= a_is_store[g] ? '0 : ld_data[g];
          wr_ptr[g]             <= wr_ptr[g] + PW'(1);
          // Lanes are visited in ascending order, so on overlapping bytes the
          // highest-index lane's write is the one that lands
          if (a_is_store[g]) begin
            for (int unsigned b = 0; b < 8; b++) begin
              if (bmask[g][b]) mem[widx[g]][8*b +: 8] <= st_shift[g][8*b +: 8];
            end
          end
        end
        if (pop[g]) rd_ptr[g] <= rd_ptr[g] + PW'(1);
        cnt[g] <= cnt[g] + CNTW'(push[g]) - CNTW'(pop[g]);
      end
    end
  end

endmodule

// File: tb/tb_sim_mem_responder.sv
module tb_sim_mem_responder;

  localparam int NL    = 4;
  localparam int DW    = 64;
  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int MW    = 256;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NL-1:0]     a_valid, a_ready, a_is_store, d_valid, d_ready, d_is_store;
  logic [DW*NL-1:0]  a_address, a_data, d_data;
  logic [SW*NL-1:0]  a_size, d_size;
  logic              inflight;
  logic [31:0]       resp_count;

  sim_mem_responder #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW),
    .DEPTH(DEPTH), .LATENCY(LAT), .MEM_WORDS(MW)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address),
    .a_is_store(a_is_store), .a_size(a_size), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_is_store(d_is_store),
    .d_size(d_size), .d_data(d_data),
    .inflight(inflight), .resp_count(resp_count)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    bit             st;
    logic [SW-1:0]  sz;
    logic [DW-1:0]  data;
    longint         ready_at;
  } ent_t;

  ent_t         mq [NL][$];
  byte unsigned mbyte [MW*8];
  bit           mready = 1'b0;
  longint       edge_no = 0;
  logic [31:0]  mresp = '0;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mload(input logic [DW-1:0] addr, input logic [SW-1:0] sz);
    int s, n, off, w;
    logic [DW-1:0] r;
    s   = (sz > 3) ? 3 : int'(sz);
    n   = 1 << s;
    off = int'(addr[2:0]) & ~(n - 1);
    w   = int'((addr / 8) % MW);
    r   = '0;
    for (int i = 0; i < n; i++) r = r | (DW'(mbyte[w*8 + off + i]) << (8*i));
    return r;
  endfunction

  task automatic mstore(input logic [DW-1:0] addr, input logic [SW-1:0] sz, input logic [DW-1:0] data);
    int s, n, off, w;
    s   = (sz > 3) ? 3 : int'(sz);
    n   = 1 << s;
    off = int'(addr[2:0]) & ~(n - 1);
    w   = int'((addr / 8) % MW);
    for (int i = 0; i < n; i++) mbyte[w*8 + off + i] = data[8*i +: 8];
  endtask

  function automatic bit head_ready(input int g);
    if (mq[g].size() == 0) return 1'b0;
    return edge_no >= mq[g][0].ready_at;
  endfunction

  task automatic mclear();
    for (int g = 0; g < NL; g++) mq[g].delete();
    for (int i = 0; i < MW*8; i++) mbyte[i] = 8'd0;
    mready = 1'b0;
    mresp  = '0;
  endtask

  always @(posedge clock or negedge reset) begin
    bit            acc [NL];
    bit            pp  [NL];
    logic [DW-1:0] ld  [NL];
    ent_t          e;
    if (!reset) begin
      mclear();
    end else begin
      for (int g = 0; g < NL; g++) begin
        pp[g]  = d_ready[g] && head_ready(g);
        acc[g] = a_valid[g] && mready && (mq[g].size() < DEPTH);
        ld[g]  = mload(a_address[DW*g +: DW], a_size[SW*g +: SW]);
      end
      for (int g = 0; g < NL; g++)
        if (acc[g] && a_is_store[g]) mstore(a_address[DW*g +: DW], a_size[SW*g +: SW], a_data[DW*g +: DW]);
      edge_no++;
      for (int g = 0; g < NL; g++) begin
        if (pp[g]) begin
          void'(mq[g].pop_front());
          mresp = mresp + 32'd1;
        end
        if (acc[g]) begin
          e.st       = a_is_store[g];
          e.sz       = a_size[SW*g +: SW];
          e.data     = a_is_store[g] ? '0 : ld[g];
          e.ready_at = edge_no + LAT;
          mq[g].push_back(e);
        end
      end
      mready = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    logic [NL-1:0] er, ev;
    bit einf;
    if (check_en) begin
      einf = 1'b0;
      for (int g = 0; g < NL; g++) begin
        er[g] = mready && (mq[g].size() < DEPTH);
        ev[g] = head_ready(g);
        if (mq[g].size() != 0) einf = 1'b1;
      end
      chk("a_ready", 64'(a_ready), 64'(er));
      chk("d_valid", 64'(d_valid), 64'(ev));
      for (int g = 0; g < NL; g++) begin
        if (ev[g]) begin
          chk("d_is_store", 64'(d_is_store[g]), 64'(mq[g][0].st));
          chk("d_size", 64'(d_size[SW*g +: SW]), 64'(mq[g][0].sz));
          chk("d_data", d_data[DW*g +: DW], mq[g][0].data);
        end
      end
      chk("inflight", 64'(inflight), 64'(einf));
      chk("resp_count", 64'(resp_count), 64'(mresp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    a_valid = '0; a_is_store = '0; a_address = '0; a_size = '0; a_data = '0;
  endtask

  task automatic req(input int g, input bit st, input logic [63:0] addr,
                     input logic [7:0] sz, input logic [63:0] data);
    a_valid[g]          = 1'b1;
    a_is_store[g]       = st;
    a_address[DW*g +: DW] = addr;
    a_size[SW*g +: SW]  = sz;
    a_data[DW*g +: DW]  = data;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  // Wait (bounded) for the next load response on lane g and check its data
  task automatic collect(input int g, input logic [63:0] exp, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (d_valid[g] && !d_is_store[g]) begin
        chk(name, d_data[DW*g +: DW], exp);
        found = 1'b1;
      end
      step();
    end
    if (!found) begin
      n_checks++;
      $display("FAIL %s: no load response on lane %0d within 20 cycles, required data %0h", name, g, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] sizes [5];
    logic [63:0] addr;
    sizes[0] = 8'd0; sizes[1] = 8'd1; sizes[2] = 8'd2; sizes[3] = 8'd3; sizes[4] = 8'd5;

    idle();
    d_ready  = '1;
    check_en = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_a_ready", 64'(a_ready), 64'h0);
    chk("reset_d_valid", 64'(d_valid), 64'h0);
    chk("reset_inflight", 64'(inflight), 64'h0);
    chk("reset_resp_count", 64'(resp_count), 64'h0);
    reset = 1'b1;
    step();
    chk("a_ready_first_edge", 64'(a_ready), 64'hF);

    // Full-word store then load
    req(0, 1'b1, 64'h10, 8'd3, 64'h1122334455667788);
    step();
    idle();
    req(0, 1'b0, 64'h10, 8'd3, 64'h0);
    step();
    idle();
    step();
    chk("store_resp_type", 64'(d_is_store[0]), 64'h1);
    chk("store_resp_data", d_data[63:0], 64'h0);
    step();
    chk("load_valid_at_latency", 64'(d_valid[0]), 64'h1);
    chk("load_full_word", d_data[63:0], 64'h1122334455667788);
    step();

    // Byte store, then wider loads over it
    do_reset();
    req(0, 1'b1, 64'h13, 8'd0, 64'hAB);
    step();
    idle();
    req(0, 1'b0, 64'h10, 8'd3, 64'h0);
    step();
    idle();
    req(0, 1'b0, 64'h12, 8'd1, 64'h0);
    step();
    idle();
    collect(0, 64'h00000000AB000000, "load_byte_in_word");
    collect(0, 64'h000000000000AB00, "load_half_aligned");

    // Same-edge stores from lanes 0 and 3, concurrent load on lane 2
    req(0, 1'b1, 64'h40, 8'd3, 64'h1);
    req(3, 1'b1, 64'h40, 8'd3, 64'h3);
    req(2, 1'b0, 64'h40, 8'd3, 64'h0);
    step();
    idle();
    req(0, 1'b0, 64'h40, 8'd3, 64'h0);
    step();
    idle();
    collect(2, 64'h0, "concurrent_load_old_data");
    collect(0, 64'h3, "highest_lane_store_wins");

    // Backpressure on lane 1
    d_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(1, 1'b1, 64'h80 + 64'(8*i), sizes[i], 64'(i));
      step();
    end
    chk("lane1_full", 64'(a_ready[1]), 64'h0);
    chk("lane0_unaffected", 64'(a_ready[0]), 64'h1);
    req(1, 1'b1, 64'hA0, sizes[4], 64'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blocked_valid", 64'(d_valid[1]), 64'h1);
      chk("blocked_size_stable", 64'(d_size[SW*1 +: SW]), 64'h0);
    end
    d_ready[1] = 1'b1;
    step();
    chk("order_size1", 64'(d_size[SW*1 +: SW]), 64'h1);
    chk("lane1_ready_after_pop", 64'(a_ready[1]), 64'h1);
    step();
    idle();
    chk("order_size2", 64'(d_size[SW*1 +: SW]), 64'h2);
    step();
    chk("order_size3", 64'(d_size[SW*1 +: SW]), 64'h3);
    step();
    chk("fifth_valid", 64'(d_valid[1]), 64'h1);
    chk("fifth_size_echo", 64'(d_size[SW*1 +: SW]), 64'h5);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int g = 0; g < NL; g++) begin
        addr       = {$urandom(), $urandom()};
        addr[10:3] = 8'($urandom_range(0, 7));
        a_valid[g]            = 1'($urandom_range(0, 1));
        a_is_store[g]         = 1'($urandom_range(0, 1));
        a_address[DW*g +: DW] = addr;
        a_size[SW*g +: SW]    = 8'($urandom_range(0, 5));
        a_data[DW*g +: DW]    = {$urandom(), $urandom()};
        d_ready[g]            = ($urandom_range(0, 9) < 7);
      end
      step();
    end
    idle();
    d_ready = '1;
    repeat (12) step();

    // Reset with entries outstanding
    d_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(0, 1'b0, 64'(8*i), 8'd3, 64'h0);
      step();
    end
    idle();
    repeat (3) step();
    chk("inflight_before_reset", 64'(inflight), 64'h1);
    chk("stuck_valid_before_reset", 64'(d_valid[0]), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_inflight", 64'(inflight), 64'h0);
    chk("async_d_valid", 64'(d_valid), 64'h0);
    chk("async_a_ready", 64'(a_ready), 64'h0);
    chk("async_resp_count", 64'(resp_count), 64'h0);
    step();
    d_ready = '1;
    reset = 1'b1;
    step();
    chk("a_ready_after_release", 64'(a_ready), 64'hF);
    for (int i = 0; i < 6; i++) begin
      chk("no_stale_d_valid", 64'(d_valid), 64'h0);
      step();
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
